// File: rtl/forwarded_data_averager.sv
// Detects word changes on a valid-less forwarded bus and averages blocks of
// 2^LOG2_COUNT updates. Also flags a stale link when no update arrives for TIMEOUT cycles.
module forwarded_data_averager #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_COUNT = 4,
  parameter int unsigned TIMEOUT    = 125000
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  sampleStrobe,
  output logic [DATA_WIDTH-1:0] avgData,
  output logic                  avgValid,
  output logic                  stale
);

  localparam int unsigned ACC_WIDTH  = DATA_WIDTH + LOG2_COUNT;
  localparam int unsigned IDLE_WIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                       state;
  logic [DATA_WIDTH-1:0]        prevData;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [LOG2_COUNT-1:0]        count;
  logic [IDLE_WIDTH-1:0]        idleCnt;

  logic                         update;
  logic                         countWrap;
  logic                         idleReach;
  logic signed [ACC_WIDTH-1:0]  dataExt;
  logic signed [ACC_WIDTH-1:0]  accSum;

  // The PRIME cycle only seeds prevData, so it can never register an update.
  assign update    = (state == RUN) && (dataIn != prevData);
  assign countWrap = (count == {LOG2_COUNT{1'b1}});
  assign idleReach = (idleCnt == IDLE_WIDTH'(TIMEOUT - 1));
  assign dataExt   = {{LOG2_COUNT{dataIn[DATA_WIDTH-1]}}, dataIn};
  assign accSum    = acc + dataExt;

  always_ff @(posedge clk) begin
    prevData <= dataIn;
    if (!resetN) begin
      state        <= PRIME;
      sampleStrobe <= 1'b0;
      avgValid     <= 1'b0;
      stale        <= 1'b0;
      avgData      <= '0;
      acc          <= '0;
      count        <= '0;
      idleCnt      <= '0;
    end else begin
      sampleStrobe <= update;
      avgValid     <= update && countWrap;
      case (state)
        PRIME: state <= RUN;
        RUN: begin
          if (update) begin
            count   <= count + LOG2_COUNT'(1);
            idleCnt <= '0;
            stale   <= 1'b0;
            if (countWrap) begin
              // Arithmetic shift floors toward minus infinity.
              avgData <= DATA_WIDTH'(accSum >>> LOG2_COUNT);
              acc     <= '0;
            end else begin
              acc <= accSum;
            end
          end else if (idleCnt != IDLE_WIDTH'(TIMEOUT)) begin
            idleCnt <= idleCnt + IDLE_WIDTH'(1);
            if (idleReach) stale <= 1'b1;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_forwarded_data_averager.sv
// Directed bench for forwarded_data_averager with DATA_WIDTH=16, LOG2_COUNT=2, TIMEOUT=10.
module tb_forwarded_data_averager;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          resetN;
  logic [DW-1:0] dataIn;
  logic          sampleStrobe;
  logic [DW-1:0] avgData;
  logic          avgValid;
  logic          stale;

  int checks = 0;
  int errors = 0;

  forwarded_data_averager #(
    .DATA_WIDTH(16),
    .LOG2_COUNT(2),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .dataIn(dataIn),
    .sampleStrobe(sampleStrobe),
    .avgData(avgData),
    .avgValid(avgValid),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply a value, advance one edge, settle just after it.
  task automatic cyc(input logic [DW-1:0] v);
    dataIn = v;
    @(posedge clk);
    #1;
  endtask

  // Reset then release with dataIn = seed; returns after the PRIME edge.
  task automatic doReset(input logic [DW-1:0] seed);
    resetN = 1'b0;
    cyc(16'd1);
    cyc(16'd2);
    cyc(16'd1);
    resetN = 1'b1;
    cyc(seed);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc((i % 2 == 0) ? 16'd1 : 16'd2);
      checks++;
      if ({sampleStrobe, avgValid, stale} !== 3'b000 || avgData !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: got strobe=%b valid=%b stale=%b avg=%0d, want 0 0 0 0",
                 sampleStrobe, avgValid, stale, avgData);
      end
    end
    resetN = 1'b1;
    cyc(16'd0);  // PRIME, dataIn differs from the reset-time word
    checks++;
    if (sampleStrobe !== 1'b0) begin
      errors++;
      $display("FAIL prime_no_strobe: got strobe=%b, want 0", sampleStrobe);
    end
  endtask

  task automatic test_basic_average();
    logic [DW-1:0] steps [4];
    int strobes = 0;
    int valids  = 0;
    steps = '{16'd10, 16'd20, 16'd30, 16'd40};
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 3; h++) begin
        cyc(steps[s]);
        strobes += int'(sampleStrobe);
        valids  += int'(avgValid);
        checks++;
        if (sampleStrobe !== (h == 0)) begin
          errors++;
          $display("FAIL basic_strobe: step %0d hold %0d got %b, want %b", s, h, sampleStrobe, h == 0);
        end
        checks++;
        if (avgValid !== (s == 3 && h == 0)) begin
          errors++;
          $display("FAIL basic_valid: step %0d hold %0d got %b, want %b", s, h, avgValid, s == 3 && h == 0);
        end
      end
    end
    checks++;
    if (strobes != 4 || valids != 1) begin
      errors++;
      $display("FAIL basic_counts: got strobes=%0d valids=%0d, want 4 1", strobes, valids);
    end
    checks++;
    if (avgData !== 16'd25) begin
      errors++;
      $display("FAIL basic_avg: got %0d, want 25", avgData);
    end
  endtask

  task automatic test_signed_average();
    logic [DW-1:0] steps [4];
    int valids = 0;
    steps = '{16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 2; h++) begin
        cyc(steps[s]);
        valids += int'(avgValid);
        if (s < 3) begin
          checks++;
          if (avgData !== 16'd25) begin
            errors++;
            $display("FAIL signed_hold: got %h, want 0019", avgData);
          end
        end
      end
    end
    checks++;
    if (avgData !== 16'hFFF9 || valids != 1) begin
      errors++;
      $display("FAIL signed_avg: got %h valids=%0d, want fff9 1", avgData, valids);
    end
  endtask

  task automatic test_stale();
    cyc(16'd100);
    for (int k = 1; k <= 12; k++) begin
      cyc(16'd100);
      checks++;
      if (stale !== (k >= 10)) begin
        errors++;
        $display("FAIL stale_rise: %0d cycles after strobe got %b, want %b", k, stale, k >= 10);
      end
    end
    cyc(16'd101);
    checks++;
    if (sampleStrobe !== 1'b1 || stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_clear: got strobe=%b stale=%b, want 1 0", sampleStrobe, stale);
    end
    for (int k = 1; k <= 9; k++) cyc(16'd101);
    cyc(16'd102);  // update coincides with the timeout edge
    checks++;
    if (sampleStrobe !== 1'b1 || stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_coincide: got strobe=%b stale=%b, want 1 0", sampleStrobe, stale);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(16'd102);
      checks++;
      if (stale !== 1'b0) begin
        errors++;
        $display("FAIL stale_restart: %0d cycles after got %b, want 0", k, stale);
      end
    end
  endtask

  task automatic test_reset_midblock();
    logic [DW-1:0] steps [4];
    int valids = 0;
    steps = '{16'd4, 16'd8, 16'd12, 16'd16};
    doReset(16'd0);
    cyc(16'd1000);
    cyc(16'd2000);
    doReset(16'd2);
    checks++;
    if (avgData !== 16'd0) begin
      errors++;
      $display("FAIL midreset_avg_cleared: got %0d, want 0", avgData);
    end
    for (int s = 0; s < 4; s++) begin
      cyc(steps[s]);
      valids += int'(avgValid);
    end
    checks++;
    if (avgData !== 16'd10 || valids != 1 || avgValid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_avg: got %0d valids=%0d last=%b, want 10 1 1", avgData, valids, avgValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] steps [4];
    steps = '{16'd32767, 16'd32766, 16'd32767, 16'd32766};
    for (int s = 0; s < 4; s++) begin
      cyc(steps[s]);
      checks++;
      if (sampleStrobe !== 1'b1 || avgValid !== (s == 3)) begin
        errors++;
        $display("FAIL b2b_strobe: update %0d got strobe=%b valid=%b, want 1 %b", s, sampleStrobe, avgValid, s == 3);
      end
    end
    checks++;
    if (avgData !== 16'd32766) begin
      errors++;
      $display("FAIL b2b_avg: got %0d, want 32766", avgData);
    end
    cyc(16'd32766);
    checks++;
    if (sampleStrobe !== 1'b0 || avgValid !== 1'b0 || avgData !== 16'd32766) begin
      errors++;
      $display("FAIL b2b_after: got strobe=%b valid=%b avg=%0d, want 0 0 32766", sampleStrobe, avgValid, avgData);
    end
  endtask

  initial begin
    resetN = 1'b0;
    dataIn = '0;
    test_reset();
    test_basic_average();
    test_signed_average();
    test_stale();
    test_reset_midblock();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
